// File: rtl/wshb_arbiter_if.sv
// Wishbone B4 classic bus bundle (32-bit data, 4 byte lanes) shared by the arbiter's
// master-side and slave-side ports.
interface wshb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  ack, err, rty, dat_sm);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output ack, err, rty, dat_sm);
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter, granting whole cyc spans to the SDRAM slave.
// Optional stall watchdog enabled by defining WSHB_ARB_TIMEOUT_EN.
module wshb_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  wshb_arbiter_if.slave  m0,
  wshb_arbiter_if.slave  m1,
  wshb_arbiter_if.master s,
  output logic [1:0]     grant
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] m_cyc, elig;
  logic       own_stb, s_resp, abort;

  assign m_cyc   = {m1.cyc, m0.cyc};
  assign s_resp  = s.ack | s.err | s.rty;
  assign own_stb = (state_q == ST_G0) ? m0.stb :
                   (state_q == ST_G1) ? m1.stb : 1'b0;

`ifdef WSHB_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  mask_q, mask_d;

  // Abort in the cycle the count hits its limit while still stalled.
  assign abort = own_stb & ~s_resp & (cnt_q == CNT_LAST);
  assign elig  = m_cyc & ~mask_q;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!own_stb || s_resp || abort || (state_d != state_q)) cnt_d = '0;
  end

  // An aborted master stays locked out until it drops cyc at least once.
  always_comb begin
    mask_d = (mask_q | ({2{abort}} & {state_q == ST_G1, state_q == ST_G0})) & m_cyc;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end
`else
  assign abort = 1'b0;
  assign elig  = m_cyc;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (elig == 2'b11)  state_d = last_q ? ST_G0 : ST_G1;
        else if (elig[0])   state_d = ST_G0;
        else if (elig[1])   state_d = ST_G1;
      end
      ST_G0: begin
        if (!m0.cyc || abort) begin
          last_d  = 1'b0;
          state_d = elig[1] ? ST_G1 : ST_IDLE;
        end
      end
      ST_G1: begin
        if (!m1.cyc || abort) begin
          last_d  = 1'b1;
          state_d = elig[0] ? ST_G0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign grant     = {state_q == ST_G1, state_q == ST_G0};
  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.adr    = '0;
    s.dat_ms = '0;
    s.sel    = '0;
    s.cti    = '0;
    s.bte    = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rty   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rty   = 1'b0;
    case (state_q)
      ST_G0: begin
        s.cyc    = m0.cyc & ~abort;
        s.stb    = m0.stb & ~abort;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_ms = m0.dat_ms;
        s.sel    = m0.sel;
        s.cti    = m0.cti;
        s.bte    = m0.bte;
        m0.ack   = s.ack;
        m0.err   = s.err | abort;
        m0.rty   = s.rty;
      end
      ST_G1: begin
        s.cyc    = m1.cyc & ~abort;
        s.stb    = m1.stb & ~abort;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_ms = m1.dat_ms;
        s.sel    = m1.sel;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
        m1.ack   = s.ack;
        m1.err   = s.err | abort;
        m1.rty   = s.rty;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wshb_arbiter.sv
// Scoreboard bench for wshb_arbiter: expected {grant, read data} queued per request,
// popped whenever a master sees ack. Watchdog tests run when WSHB_ARB_TIMEOUT_EN is defined.
module tb_wshb_arbiter;
  localparam logic [31:0] K = 32'hCAFEF10D;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [1:0] grant;
  int         n_chk = 0;
  int         n_err = 0;
  logic [33:0] sb[$];
  logic        pend;
  logic [31:0] pdat;

  wshb_arbiter_if m0_if();
  wshb_arbiter_if m1_if();
  wshb_arbiter_if s_if();

  wshb_arbiter #(.TIMEOUT(16)) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .s       (s_if.master),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_set(input int idx, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    if (idx == 0) begin
      m0_if.cyc = cyc; m0_if.stb = cyc; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_ms = adr + 32'd1; m0_if.sel = 4'hF; m0_if.cti = cti; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = cyc; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_ms = adr + 32'd1; m1_if.sel = 4'hF; m1_if.cti = cti; m1_if.bte = 2'b00;
    end
  endtask

  task automatic wait_ack(input int idx, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (idx == 0) ? m0_if.ack : m1_if.ack;
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else if (idx == 0) chk({tag, "_other"}, {m1_if.ack, m1_if.err, m1_if.rty}, 32'd0);
    else               chk({tag, "_other"}, {m0_if.ack, m0_if.err, m0_if.rty}, 32'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    m_set(1, 1'b0, 1'b0, 32'd0, 3'd0);
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  // Slave model: acks one cycle after seeing a strobe, never for adr[31] set.
  initial begin
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.rty = 1'b0; s_if.dat_sm = '0;
    forever begin
      @(negedge clk);
      pend = s_if.cyc & s_if.stb & ~s_if.ack & ~s_if.adr[31];
      pdat = s_if.adr ^ K;
      @(posedge clk);
      #1;
      s_if.ack    = pend;
      s_if.dat_sm = pend ? pdat : 32'd0;
    end
  end

  always @(negedge clk) begin
    if (m0_if.ack || m1_if.ack) begin
      if (sb.size() == 0) chk("sb_unexpected_ack", 32'd1, 32'd0);
      else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("sb_grant", {30'd0, grant}, {30'd0, e[33:32]});
        chk("sb_ack_owner", {30'd0, m1_if.ack, m0_if.ack}, {30'd0, e[33:32]});
        chk("sb_data", m0_if.ack ? m0_if.dat_sm : m1_if.dat_sm, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a0, a1;
    do_reset();
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_scyc", {31'd0, s_if.cyc}, 32'd0);
    chk("rst_sadr", s_if.adr, 32'd0);
    chk("rst_mresp", {m0_if.ack, m0_if.err, m0_if.rty, m1_if.ack, m1_if.err, m1_if.rty}, 32'd0);

    // Single read by master 0
    tick(); m_set(0, 1'b1, 1'b0, 32'h100, 3'd0);
    sb.push_back({2'b01, 32'hCAFEF00D});
    @(negedge clk);
    chk("rd_pre_grant", {30'd0, grant}, 32'd0);
    chk("rd_pre_scyc", {31'd0, s_if.cyc}, 32'd0);
    tick(); @(negedge clk);
    chk("rd_scyc_stb", {30'd0, s_if.cyc, s_if.stb}, 32'd3);
    chk("rd_sadr", s_if.adr, 32'h100);
    chk("rd_grant", {30'd0, grant}, 32'd1);
    wait_ack(0, "rd_ack");
    chk("rd_ack_eq_s", {31'd0, m0_if.ack}, {31'd0, s_if.ack});
    tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    @(negedge clk);
    chk("rd_drop_scyc", {31'd0, s_if.cyc}, 32'd0);
    tick(); @(negedge clk);
    chk("rd_idle_grant", {30'd0, grant}, 32'd0);

    // Simultaneous requests alternate round-robin
    do_reset();
    for (int r = 0; r < 4; r++) begin
      a0 = 32'h1000 + 32'(r * 16);
      a1 = 32'h2000 + 32'(r * 16);
      tick();
      m_set(0, 1'b1, 1'b0, a0, 3'd0);
      m_set(1, 1'b1, 1'b0, a1, 3'd0);
      sb.push_back({2'b01, a0 ^ K});
      sb.push_back({2'b10, a1 ^ K});
      tick(); @(negedge clk);
      chk("tie_first_grant", {30'd0, grant}, 32'd1);
      wait_ack(0, "tie_m0");
      tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
      wait_ack(1, "tie_m1");
      tick(); m_set(1, 1'b0, 1'b0, 32'd0, 3'd0);
    end

    // Master 1 burst must not be split by a master 0 request
    tick(); m_set(1, 1'b1, 1'b0, 32'h3000, 3'b010);
    for (int b = 0; b < 8; b++) sb.push_back({2'b10, (32'h3000 + 32'(b * 4)) ^ K});
    sb.push_back({2'b01, 32'h400 ^ K});
    tick(); m_set(0, 1'b1, 1'b0, 32'h400, 3'd0);
    @(negedge clk);
    chk("burst_grant", {30'd0, grant}, 32'd2);
    for (int b = 0; b < 8; b++) begin
      wait_ack(1, "burst_beat");
      chk("burst_hold", {30'd0, grant}, 32'd2);
      chk("burst_cti", {29'd0, s_if.cti}, (b == 7) ? 32'd7 : 32'd2);
      tick();
      if (b < 7) m_set(1, 1'b1, 1'b0, 32'h3000 + 32'((b + 1) * 4), (b == 6) ? 3'b111 : 3'b010);
      else       m_set(1, 1'b0, 1'b0, 32'd0, 3'd0);
    end
    @(negedge clk);
    chk("ho_gap_scyc", {31'd0, s_if.cyc}, 32'd0);
    chk("ho_gap_grant", {30'd0, grant}, 32'd2);
    tick(); @(negedge clk);
    chk("ho_grant", {30'd0, grant}, 32'd1);
    chk("ho_scyc", {31'd0, s_if.cyc}, 32'd1);
    chk("ho_sadr", s_if.adr, 32'h400);
    wait_ack(0, "ho_m0");
    tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    tick();

    // Reset during a granted (stalled) write; last pointer must return to 1
    tick(); m_set(0, 1'b1, 1'b1, 32'h8000_0010, 3'd0);
    tick(); @(negedge clk);
    chk("rw_grant", {30'd0, grant}, 32'd1);
    chk("rw_swe", {31'd0, s_if.we}, 32'd1);
    tick(); sys_rst = 1'b1;
    tick(); sys_rst = 1'b0;
    m_set(0, 1'b1, 1'b0, 32'h500, 3'd0);
    m_set(1, 1'b1, 1'b0, 32'h600, 3'd0);
    sb.push_back({2'b01, 32'h500 ^ K});
    sb.push_back({2'b10, 32'h600 ^ K});
    @(negedge clk);
    chk("rw_rst_scyc", {31'd0, s_if.cyc}, 32'd0);
    chk("rw_rst_grant", {30'd0, grant}, 32'd0);
    tick(); @(negedge clk);
    chk("rw_last_tie", {30'd0, grant}, 32'd1);
    wait_ack(0, "rw_m0");
    tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    wait_ack(1, "rw_m1");
    tick(); m_set(1, 1'b0, 1'b0, 32'd0, 3'd0);
    tick();

`ifdef WSHB_ARB_TIMEOUT_EN
    // Watchdog: master 0 stalls, errors out on the 16th stalled cycle
    tick(); m_set(0, 1'b1, 1'b0, 32'h8000_0000, 3'd0);
    tick(); m_set(1, 1'b1, 1'b0, 32'h40, 3'd0);
    sb.push_back({2'b10, 32'h40 ^ K});
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) chk("to_no_err", {30'd0, m0_if.err, ~s_if.cyc}, 32'd0);
      else begin
        chk("to_err", {31'd0, m0_if.err}, 32'd1);
        chk("to_scyc", {30'd0, s_if.cyc, s_if.stb}, 32'd0);
      end
      tick();
    end
    @(negedge clk);
    chk("to_handover", {30'd0, grant}, 32'd2);
    chk("to_err_pulse", {31'd0, m0_if.err}, 32'd0);
    wait_ack(1, "to_m1");
    tick(); m_set(1, 1'b0, 1'b0, 32'd0, 3'd0);
    tick(); @(negedge clk);
    chk("to_masked_a", {30'd0, grant}, 32'd0);
    tick(); @(negedge clk);
    chk("to_masked_b", {30'd0, grant}, 32'd0);
    tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    tick(); m_set(0, 1'b1, 1'b0, 32'h200, 3'd0);
    sb.push_back({2'b01, 32'h200 ^ K});
    @(negedge clk);
    chk("to_regrant_pre", {30'd0, grant}, 32'd0);
    tick(); @(negedge clk);
    chk("to_regrant", {30'd0, grant}, 32'd1);
    wait_ack(0, "to_m0");
    tick(); m_set(0, 1'b0, 1'b0, 32'd0, 3'd0);
    tick();
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wshb_arbiter.md
# wshb_arbiter

Two-master Wishbone arbiter that shares the single SDRAM Wishbone slave port (`wshb_if_sdram`, 32-bit data, 4 byte lanes) between the video frame-buffer reader (master 0) and the pattern/frame writer (master 1). The block lives in the `sys_clk` domain between the student video masters and `hw_support`. It grants the bus per Wishbone cycle (whole `cyc` span), forwards the granted master to the slave, and isolates the other master. Arbitration is round-robin, and an optional watchdog aborts a stalled transfer.

## Interface
Parameters:
- `TIMEOUT`, 1023: watchdog limit, in cycles of `stb` high without `ack`/`err`/`rty`. Range 2..65535.

Ports:
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst` in 1: reset, synchronous, active-high.
- `mN_cyc`, `mN_stb`, `mN_we` in 1 each (N = 0, 1): master N Wishbone controls.
- `mN_adr` in 32: master N byte address.
- `mN_dat_ms` in 32: master N write data.
- `mN_sel` in 4: master N byte lanes.
- `mN_cti` in 3, `mN_bte` in 2: master N burst tags.
- `mN_ack`, `mN_err`, `mN_rty` out 1 each: master N responses.
- `mN_dat_sm` out 32: read data to master N.
- `s_cyc`, `s_stb`, `s_we` out 1 each: to slave.
- `s_adr` out 32, `s_dat_ms` out 32, `s_sel` out 4, `s_cti` out 3, `s_bte` out 2: to slave.
- `s_ack`, `s_err`, `s_rty` in 1 each: slave responses.
- `s_dat_sm` in 32: read data from slave.
- `grant` out 2: one-hot current owner (bit N = master N); 2'b00 when idle. Used for LEDs and debug.

## Operation
- States:
  - IDLE: no owner.
  - G0: master 0 owns the bus.
  - G1: master 1 owns the bus.
- IDLE, single request: if exactly one eligible `mN_cyc` is high, go to GN on the next edge.
- IDLE, both requesting: the master that was not granted last wins (`last` pointer). After reset `last` = 1, so master 0 wins the first tie.
- GN, owner keeps `mN_cyc` high: stay in GN. There is no preemption, and bursts (`cti`=3'b010) are never split.
- GN, owner drops `mN_cyc`:
  - If the other master's `cyc` is high, go directly to the other grant state (no idle cycle).
  - Otherwise go to IDLE.
  - In both cases set `last` = N.
- Forwarding is combinational from the owner:
  - Owner's request signals drive all `s_*` outputs.
  - Slave responses (`ack`/`err`/`rty`) go to the owner only.
  - `s_dat_sm` fans out to both `mN_dat_sm`.
- Non-owner: `ack`/`err`/`rty` held at 0. Its requests are ignored; it waits with `cyc`/`stb` high per Wishbone rules.
- IDLE outputs: `s_cyc` = `s_stb` = `s_we` = 0. `s_adr`, `s_dat_ms`, `s_sel`, `s_cti`, `s_bte` = 0.
- A master is eligible unless its `mask` bit is set (see Configuration). Without the watchdog, both masters are always eligible.

## Timing
- Reset values:
  - State IDLE, `last` = 1, `grant` = 0, `mask` = 0, watchdog count = 0.
  - All `s_*` request outputs 0.
  - All `mN_ack`/`err`/`rty` 0.
- Grant latency is one cycle:
  - `cyc` first sampled high in IDLE at edge k.
  - `s_cyc`/`s_stb` follow the master from cycle k+1.
  - `mN_ack` appears in the same cycle as `s_ack` (zero added response latency).
- Handover: owner `cyc` low at edge k, other master requesting → other master forwarded from cycle k+1. The slave sees `s_cyc` low for exactly that one cycle (cycle k).
- Simultaneous first requests in IDLE resolve by the `last` pointer within the same cycle.
- `sys_rst` mid-transfer: next cycle is IDLE with `s_cyc` = 0. Masters are reset by the same `sys_rst`.

## Configuration
- Macro: `WSHB_ARB_TIMEOUT_EN`.
- Defined: a 16-bit counter runs in GN.
  - Counts up each cycle the owner has `stb` high and the slave returns none of `ack`/`err`/`rty`.
  - Clears on any response, or when `stb` is low.
  - When the count reaches `TIMEOUT − 1`, the arbiter does the following in that cycle:
    - drives `mN_err` = 1 to the owner for one cycle;
    - forces `s_cyc` = `s_stb` = 0;
    - sets `mask[N]`.
  - The next state is computed as if the owner had dropped `cyc`.
  - `mask[N]` clears on the first cycle `mN_cyc` is low. Until then master N cannot be granted.
- Undefined: no counter and no mask. A stalled slave holds the grant indefinitely.

## Test plan
- Reset, then no requests: `grant` = 00, `s_cyc` = 0. Master 1 is ignored while only master 0 cycles.
- Master 0 single read at adr 0x100: cycle k+1 `s_cyc`/`s_stb` = 1, `s_adr` = 0x100. Slave `ack` with data 0xCAFEF00D → `m0_ack` = 1, `m0_dat_sm` = 0xCAFEF00D. `grant` = 01 → 00.
- Both masters request in the same cycle, repeated four times (each drops `cyc` after one ack): grants alternate 01, 10, 01, 10.
- Master 1 holds an 8-beat burst (`cti` 010→111) while master 0 requests:
  - no grant change until `m1_cyc` falls;
  - then `grant` = 01 on the next cycle, with exactly one idle `s_cyc` cycle.
- `WSHB_ARB_TIMEOUT_EN` with `TIMEOUT` = 16, slave never acks master 0:
  - `m0_err` pulses in the 16th stalled cycle and `s_cyc` drops;
  - a pending master 1 is granted next;
  - master 0 is not regranted until `m0_cyc` has been low for one cycle.
- `sys_rst` asserted during a granted write: next cycle `s_cyc` = 0, `grant` = 00, `last` = 1.
